accu_n: RTL and testbench

ACCU_N -- requirements
Module: accu_n

---
 rtl/accu_n_pkg.sv | 36 +++
 rtl/accu_n_oreg.sv | 65 ++++++
 rtl/accu_n.sv | 128 ++++++++++++
 tb/tb_accu_n.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accu_n_pkg.sv
// accu_n_pkg -- shared definitions for the accu_n group accumulator.
//   clog2            : constant ceiling-log2 used for width derivation
//   calc_out_w       : sum width, DATA_W + clog2(GROUP_N), wide enough for a full group of max samples
//   calc_cnt_w       : count width, clog2(GROUP_N+1), wide enough to hold GROUP_N itself
//   acc_state_e      : accumulator FSM states
//   slot_state_e     : output slot states
package accu_n_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int p = 1; p < value; p = p * 2) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int calc_out_w(input int data_w, input int group_n);
    return data_w + clog2(group_n);
  endfunction

  function automatic int calc_cnt_w(input int group_n);
    return clog2(group_n + 1);
  endfunction

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/accu_n_oreg.sv
// accu_n_oreg -- single-entry output slot of accu_n.
// Holds one closed group (sum + sample count) until the downstream side takes it.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_in      : a group closes this cycle; capture load_sum/load_cnt
//   load_sum     : final group sum
//   load_cnt     : number of samples in the group
//   ready_down   : downstream accepts the slot contents
//   data_out     : held group sum
//   count_out    : held sample count
//   valid_out    : slot is FULL
module accu_n_oreg
  import accu_n_pkg::*;
#(
  parameter int OUT_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_in,
  input  logic [OUT_W-1:0] load_sum,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             ready_down,
  output logic [OUT_W-1:0] data_out,
  output logic [CNT_W-1:0] count_out,
  output logic             valid_out
);

  slot_state_e      slot_q, slot_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_EMPTY;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // A load wins over a transfer: when the held group leaves on the same edge
  // a new one closes, the slot simply refills and stays FULL. The top only
  // raises load_in when the slot is empty or being drained this edge.
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_in) begin
      slot_d = SLOT_FULL;
      data_d = load_sum;
      cnt_d  = load_cnt;
    end else if ((slot_q == SLOT_FULL) && ready_down) begin
      slot_d = SLOT_EMPTY;
    end
  end

  assign data_out  = data_q;
  assign count_out = cnt_q;
  assign valid_out = (slot_q == SLOT_FULL);

endmodule

// File: rtl/accu_n.sv
// accu_n -- sums groups of GROUP_N unsigned samples and emits one result per group.
// Optional feature: define ACCU_N_FLUSH_EN to add flush_in, which closes a partial group early.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : unsigned sample (DATA_W)
//   valid_in    : sample present this cycle
//   ready_up    : block accepts a sample this cycle
//   flush_in    : close the current partial group (only with ACCU_N_FLUSH_EN)
//   data_out    : group sum (OUT_W)
//   count_out   : samples in data_out (CNT_W)
//   valid_out   : data_out/count_out valid
//   ready_down  : downstream accepts the output
module accu_n
  import accu_n_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int GROUP_N = 4,
  localparam int OUT_W   = calc_out_w(DATA_W, GROUP_N),
  localparam int CNT_W   = calc_cnt_w(GROUP_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_up,
`ifdef ACCU_N_FLUSH_EN
  input  logic              flush_in,
`endif
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              valid_out,
  input  logic              ready_down
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_N - 1);

  acc_state_e       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flush_req;
  logic             closing_pending;
  logic             accept;
  logic             close;
  logic [OUT_W-1:0] close_sum;
  logic [CNT_W-1:0] close_cnt;
  logic [OUT_W-1:0] sum_next;

`ifdef ACCU_N_FLUSH_EN
  assign flush_req = flush_in;
`else
  assign flush_req = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output logic: only a cycle that would close a group can be stalled, and
  // only while the slot is occupied and not draining. The stall is decided
  // from the pending-close condition, never from valid_in/data_in, so the
  // whole close (partial sum, count, sample) waits upstream intact.
  always_comb begin
    closing_pending = (cnt_q == LAST_CNT) || flush_req;
    ready_up        = !(valid_out && !ready_down && closing_pending);
    accept          = valid_in && ready_up;
  end

  // Next-state and accumulator update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    close     = 1'b0;
    close_sum = acc_q;
    close_cnt = cnt_q;
    sum_next  = ((state_q == ACC_IDLE) ? '0 : acc_q) + OUT_W'(data_in);

    if (accept) begin
      if ((cnt_q == LAST_CNT) || flush_req) begin
        close     = 1'b1;
        close_sum = sum_next;
        close_cnt = cnt_q + CNT_W'(1);
        state_d   = ACC_IDLE;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        state_d = ACC_RUN;
        acc_d   = sum_next;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (flush_req && ready_up && (state_q == ACC_RUN) && !valid_in) begin
      // Flush with no sample closes what has been gathered so far; in IDLE
      // there is nothing to close and the flush is ignored.
      close     = 1'b1;
      close_sum = acc_q;
      close_cnt = cnt_q;
      state_d   = ACC_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
    end
  end

  accu_n_oreg #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_oreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_in    (close),
    .load_sum   (close_sum),
    .load_cnt   (close_cnt),
    .ready_down (ready_down),
    .data_out   (data_out),
    .count_out  (count_out),
    .valid_out  (valid_out)
  );

endmodule

// File: tb/tb_accu_n.sv
// tb_accu_n -- self-checking bench for accu_n (DATA_W=8, GROUP_N=4) plus a
// DATA_W=4, GROUP_N=5 instance. Flush scenarios run when ACCU_N_FLUSH_EN is defined.
module tb_accu_n;

  localparam int GN = 4;
`ifdef ACCU_N_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       flush_in;
  logic       ready_down;
  logic       ready_up;
  logic [9:0] data_out;
  logic [2:0] count_out;
  logic       valid_out;

  logic [3:0] d5;
  logic       v5;
  logic       ru5;
  logic [6:0] do5;
  logic [2:0] co5;
  logic       vo5;
  logic       rd5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  accu_n #(.DATA_W(8), .GROUP_N(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_up   (ready_up),
`ifdef ACCU_N_FLUSH_EN
    .flush_in   (flush_in),
`endif
    .data_out   (data_out),
    .count_out  (count_out),
    .valid_out  (valid_out),
    .ready_down (ready_down)
  );

  accu_n #(.DATA_W(4), .GROUP_N(5)) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (d5),
    .valid_in   (v5),
    .ready_up   (ru5),
`ifdef ACCU_N_FLUSH_EN
    .flush_in   (1'b0),
`endif
    .data_out   (do5),
    .count_out  (co5),
    .valid_out  (vo5),
    .ready_down (rd5)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [9:0] sum;
    logic [2:0] cnt;
  } res_t;

  res_t sbq[$];
  int   m_acc  = 0;
  int   m_cnt  = 0;
  bit   m_full = 1'b0;

  // Evaluated at the falling edge: inputs are stable, and the decisions made
  // here describe what the following rising edge does.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  = 0;
      m_cnt  = 0;
      m_full = 1'b0;
      sbq.delete();
    end else begin
      bit   fl, pend, eru, xfer, took, close;
      res_t r;
      fl   = FLUSH_EN && flush_in;
      pend = (m_cnt == GN - 1) || fl;
      eru  = !(m_full && !ready_down && pend);
      check("sb_ready_up", ready_up, eru);
      check("sb_valid_out", valid_out, m_full);
      xfer = m_full && ready_down;
      if (xfer && valid_out) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          r = sbq.pop_front();
          check("sb_data_out", data_out, r.sum);
          check("sb_count_out", count_out, r.cnt);
        end
      end
      took  = valid_in && eru;
      close = 1'b0;
      if (took) begin
        m_acc = m_acc + data_in;
        m_cnt = m_cnt + 1;
        if ((m_cnt == GN) || fl) close = 1'b1;
      end else if (fl && eru && (m_cnt > 0)) begin
        close = 1'b1;
      end
      if (close) begin
        r.sum = 10'(m_acc);
        r.cnt = 3'(m_cnt);
        sbq.push_back(r);
        m_acc  = 0;
        m_cnt  = 0;
        m_full = 1'b1;
      end else if (xfer) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic fl);
    bit took;
    int n;
    data_in  = d;
    valid_in = 1'b1;
    flush_in = fl;
    took     = 1'b0;
    n        = 0;
    while (!took && (n < 100)) begin
      @(negedge clk);
      took = ready_up;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) check("send_timeout", 0, 1);
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       ev;
    logic [9:0] ed;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd1,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[1]  = '{8'd2,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[2]  = '{8'd3,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[3]  = '{8'd14,  1'b1, 1'b1, 10'd20,   3'd4};
    vecs[4]  = '{8'd5,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[5]  = '{8'd2,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[6]  = '{8'd103, 1'b1, 1'b0, 10'd0,    3'd0};
    vecs[7]  = '{8'd4,   1'b1, 1'b1, 10'd114,  3'd4};
    vecs[8]  = '{8'd5,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[9]  = '{8'd6,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[10] = '{8'd3,   1'b1, 1'b0, 10'd0,    3'd0};
    vecs[11] = '{8'd54,  1'b1, 1'b1, 10'd68,   3'd4};
    vecs[12] = '{8'd255, 1'b1, 1'b0, 10'd0,    3'd0};
    vecs[13] = '{8'd255, 1'b1, 1'b0, 10'd0,    3'd0};
    vecs[14] = '{8'd255, 1'b1, 1'b0, 10'd0,    3'd0};
    vecs[15] = '{8'd255, 1'b1, 1'b1, 10'd1020, 3'd4};
    vecs[16] = '{8'd0,   1'b0, 1'b0, 10'd0,    3'd0};

    rst_n      = 1'b0;
    data_in    = '0;
    valid_in   = 1'b0;
    flush_in   = 1'b0;
    ready_down = 1'b1;
    d5         = '0;
    v5         = 1'b0;
    rd5        = 1'b1;

    // reset state
    idle(2);
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_count_out", count_out, 0);
    check("rst_ready_up", ready_up, 1);
    rst_n = 1'b1;
    idle(1);

    // back-to-back groups and full-scale group, one sample per cycle
    for (int i = 0; i < 17; i++) begin
      data_in  = vecs[i].d;
      valid_in = vecs[i].v;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_out", i), valid_out, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data_out", i), data_out, vecs[i].ed);
        check($sformatf("vec%0d_count_out", i), count_out, vecs[i].ec);
      end
    end
    valid_in = 1'b0;
    idle(2);

    // stalled close: slot held at 20, closing sample waits upstream
    ready_down = 1'b0;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd14, 1'b0);
    check("stall_first_valid", valid_out, 1);
    check("stall_first_data", data_out, 20);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    data_in  = 8'd1;
    valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready_up", ready_up, 0);
      @(posedge clk);
      #1;
      check("stall_hold_data", data_out, 20);
      check("stall_hold_valid", valid_out, 1);
    end
    ready_down = 1'b1;
    @(negedge clk);
    check("release_ready_up", ready_up, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("reload_valid", valid_out, 1);
    check("reload_data", data_out, 4);
    check("reload_count", count_out, 4);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    check("second_group_data", data_out, 4);
    check("second_group_valid", valid_out, 1);
    idle(2);
    check("drained_valid", valid_out, 0);

`ifdef ACCU_N_FLUSH_EN
    // flush closes a partial group, a flushed sample in IDLE, and an empty flush
    send(8'd7, 1'b0);
    send(8'd9, 1'b0);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    check("flush_valid", valid_out, 1);
    check("flush_data", data_out, 16);
    check("flush_count", count_out, 2);
    send(8'd3, 1'b1);
    check("flush_one_valid", valid_out, 1);
    check("flush_one_data", data_out, 3);
    check("flush_one_count", count_out, 1);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    check("flush_idle_valid", valid_out, 0);
    idle(2);
`endif

    // asynchronous reset mid-group with an unsent result in the slot
    ready_down = 1'b0;
    send(8'd10, 1'b0);
    send(8'd10, 1'b0);
    send(8'd10, 1'b0);
    send(8'd10, 1'b0);
    check("pre_reset_data", data_out, 40);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid_out, 0);
    check("async_rst_data", data_out, 0);
    check("async_rst_count", count_out, 0);
    check("async_rst_ready", ready_up, 1);
    rst_n      = 1'b1;
    ready_down = 1'b1;
    @(posedge clk);
    #1;
    send(8'd4, 1'b0);
    send(8'd4, 1'b0);
    send(8'd4, 1'b0);
    send(8'd4, 1'b0);
    check("post_rst_valid", valid_out, 1);
    check("post_rst_data", data_out, 16);
    check("post_rst_count", count_out, 4);
    idle(2);

    // GROUP_N=5, DATA_W=4 instance
    for (int k = 0; k < 5; k++) begin
      d5 = 4'd15;
      v5 = 1'b1;
      @(posedge clk);
      #1;
      if (k == 3) check("g5_not_yet_valid", vo5, 0);
    end
    v5 = 1'b0;
    check("g5_valid", vo5, 1);
    check("g5_data", do5, 75);
    check("g5_count", co5, 5);
    idle(2);
    check("g5_drained", vo5, 0);

    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
